clock_param: RTL and testbench
==============================

CLOCK_PARAM -- requirements
Module: clock_param

Interface
- REQ-001 SHALL have parameter CLK_HZ, default 100000000, input clock frequency in Hz.
- REQ-002 SHALL have parameter SCAN_HZ, default 1000, digit-advance rate in Hz; CLK_HZ/SCAN_HZ SHALL be an integer of at least 2.
- REQ-003 SHALL have parameter NUM_DIGITS, default 8, number of digit selects; legal range is 6..8.
- REQ-004 SHALL have parameter CHIME_SEC, default 10, hourly-chime LED duration in seconds (1..59).
- REQ-005 SHALL have parameter ALARM_RST_H, default 7, alarm hour loaded at reset (0..23).
- REQ-006 SHALL have these ports, in this order:
  - clk_100Mhz, input, 1: sole clock, rising edge.
  - rst_n, input, 1: asynchronous, active-low reset.
  - minute_change, input, 1: asynchronous button; each rising edge is one minute-advance request.
  - hour_change, input, 1: asynchronous button; each rising edge is one hour-advance request.
  - mode, input, 1: level; 0 = 24-hour display, 1 = 12-hour display.
  - alarm_en, input, 1: level; 1 = adjust and display the alarm time.
  - select, output, NUM_DIGITS: active-low digit select, one-hot-low.
  - number, output, 8: active-low segments; bit7 = dp, bits6..0 = g..a.
  - led1, output, 1: PM indicator.
  - led2, output, 1: hourly chime.
  - led3, output, 1: alarm.

Function
- REQ-007 SHALL provide a tick counter 0..CLK_HZ-1 and assert internal tick1 for exactly one cycle when the counter equals CLK_HZ-1.
- REQ-008 SHALL keep time as binary registers sec 0..59, min 0..59, hour 0..23.
- On tick1:
  - sec SHALL increment and wrap 59->0.
  - sec wrap SHALL carry into min, wrapping 59->0.
  - min wrap SHALL carry into hour, wrapping 23->0.
- REQ-009 Button inputs:
  - minute_change and hour_change SHALL each pass through a 2-flop synchronizer.
  - A rising edge SHALL be detected on the synchronized level.
  - Each detected edge SHALL produce exactly one increment, 2 to 3 cycles after the input edge.
- REQ-010 Minute adjust SHALL increment min modulo 60 with no carry into hour; hour adjust SHALL increment hour modulo 24.
  - Target is the time registers when alarm_en=0, the alarm registers when alarm_en=1.
- REQ-011 If a minute or hour adjust and a tick1 coincide on the time registers:
  - sec SHALL still increment.
  - The adjust SHALL be applied.
  - The tick's carry into the adjusted field SHALL be discarded.
- REQ-012 Display digit map:
  - When alarm_en=1: digits 0..5 = 0, 0, amin%10, amin/10, ahour%10, ahour/10.
  - Otherwise: digits 0..5 = sec%10, sec/10, min%10, min/10, disp_hour%10, disp_hour/10.
  - Digits 6..NUM_DIGITS-1 SHALL be blank (number=8'hFF).
- REQ-013 disp_hour:
  - When mode=1: 12 if hour%12==0, else hour%12.
  - When mode=0: hour.
  - led1 SHALL equal mode AND (hour >= 12), using the displayed hour source.
- REQ-014 Segment encoding with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
  - dp (bit7) SHALL be 0 on digit 2 during the first half of each second while alarm_en=0, else 1.
- REQ-015 Scan:
  - Digit index SHALL advance every CLK_HZ/SCAN_HZ cycles and wrap from NUM_DIGITS-1 to 0.
  - select and number SHALL be registered and change in the same cycle, so no stale pairing is possible.
- REQ-016 led2 SHALL rise on the cycle after time reaches mm:ss = 00:00 through counting, stay high CHIME_SEC seconds, and not be triggered by adjustment.
- REQ-017 led3 SHALL be high whenever the time hour:min equals the alarm hour:min and alarm_en=0, giving 60 s of assertion when counting through.

Reset
- REQ-018 rst_n low SHALL asynchronously clear:
  - tick counter, scan counter and digit index.
  - time to 00:00:00.
  - synchronizers.
- REQ-019 rst_n low SHALL set the alarm to ALARM_RST_H:00.
- REQ-020 rst_n low SHALL force outputs to select = all ones, number=8'hFF, led1=0, led2=0, led3=0.
- REQ-021 After rst_n is released, the first tick1 SHALL occur CLK_HZ cycles later; a chime in progress at reset SHALL be cancelled.

Configuration
- REQ-022 Macro CLOCK_ALARM_EN:
  - When defined: alarm registers, alarm adjust, alarm display and led3 SHALL be implemented.
  - When undefined: led3 SHALL be tied to 0, alarm_en SHALL be ignored (treated as 0), and no alarm registers SHALL exist.

Verification
- REQ-023 Bench SHALL use CLK_HZ=20, SCAN_HZ=10, NUM_DIGITS=8, CHIME_SEC=3 and cover:
  - Reset mid-count at 05:17:42 -> all outputs at reset values immediately; time 00:00:00; first tick after 20 cycles.
  - Preload 23:59:59 plus one tick -> 00:00:00; led2 high 3 s starting next cycle; led1=0 with mode=1.
  - mode=1, hour=0 -> digits 5..4 show 1,2 (F9, A4); hour=13 -> 0,1 (C0, F9) with led1=1.
  - minute_change pulse at min=59 -> min=0 and hour unchanged; pulse coincident with tick at sec=59 -> min+1 only, sec=0.
  - With CLOCK_ALARM_EN, alarm_en=1 and two hour_change pulses -> alarm 09:00 shown with sec digits C0; alarm_en=0 with time 08:59:59 plus one tick -> led3 high for 60 s.
  - Scan over 8 digit periods -> select walks FE, FD, FB, F7, EF, DF, BF, 7F with digits 6 and 7 showing FF; CLOCK_ALARM_EN undefined -> led3 constantly 0.

Source files
------------

// File: rtl/clock_param.sv
// Binary-time clock with multiplexed active-low 7-segment scan, hourly chime and button adjust.
// Define CLOCK_ALARM_EN to build the alarm registers, alarm adjust/display and led3.
module clock_param #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned SCAN_HZ     = 1000,
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned CHIME_SEC   = 10,
    parameter int unsigned ALARM_RST_H = 7
) (
    input  logic                  clk_100Mhz,
    input  logic                  rst_n,
    input  logic                  minute_change,
    input  logic                  hour_change,
    input  logic                  mode,
    input  logic                  alarm_en,
    output logic [NUM_DIGITS-1:0] select,
    output logic [7:0]            number,
    output logic                  led1,
    output logic                  led2,
    output logic                  led3
);
    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W    = $clog2(CLK_HZ);
    localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DIG_W    = $clog2(NUM_DIGITS);
    localparam int unsigned CHM_W    = $clog2(CHIME_SEC + 1);

    logic [CNT_W-1:0]      tick_cnt;
    logic [SCAN_W-1:0]     scan_cnt;
    logic [DIG_W-1:0]      digit;
    logic [5:0]            sec, min;
    logic [4:0]            hour;
    logic [2:0]            min_sync, hr_sync;
    logic [CHM_W-1:0]      chime_cnt;
    logic                  tick1, min_edge, hr_edge, alarm_sel;
    logic                  sec_wrap, min_wrap, t_min_adj, t_hr_adj;
    logic [5:0]            sec_nx, min_nx;
    logic [4:0]            hour_nx;
    logic [5:0]            d_sec, d_min;
    logic [4:0]            d_hour, h12;
    logic                  pm;
    logic [3:0]            dval;
    logic                  blank;
    logic [7:0]            seg_nx;
    logic [NUM_DIGITS-1:0] select_nx;
    logic                  alarm_match;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 8'hC0;
            4'd1:    seg_of = 8'hF9;
            4'd2:    seg_of = 8'hA4;
            4'd3:    seg_of = 8'hB0;
            4'd4:    seg_of = 8'h99;
            4'd5:    seg_of = 8'h92;
            4'd6:    seg_of = 8'h82;
            4'd7:    seg_of = 8'hF8;
            4'd8:    seg_of = 8'h80;
            4'd9:    seg_of = 8'h90;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    assign tick1    = (tick_cnt == CNT_W'(CLK_HZ - 1));
    // Bits [1:0] are the synchronizer, bit 2 holds the previous synchronized level.
    assign min_edge = min_sync[1] & ~min_sync[2];
    assign hr_edge  = hr_sync[1] & ~hr_sync[2];

`ifdef CLOCK_ALARM_EN
    logic [5:0] amin;
    logic [4:0] ahour;

    assign alarm_sel   = alarm_en;
    assign alarm_match = !alarm_sel && (hour == ahour) && (min == amin);

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            amin  <= 6'd0;
            ahour <= 5'(ALARM_RST_H);
        end else begin
            if (min_edge && alarm_sel) amin  <= (amin == 6'd59) ? 6'd0 : amin + 6'd1;
            if (hr_edge && alarm_sel)  ahour <= (ahour == 5'd23) ? 5'd0 : ahour + 5'd1;
        end
    end
`else
    logic unused_alarm_en;

    assign unused_alarm_en = alarm_en;
    assign alarm_sel       = 1'b0;
    assign alarm_match     = 1'b0;
`endif

    // An adjust on a field swallows the tick's carry into that same field.
    always_comb begin
        t_min_adj = min_edge & ~alarm_sel;
        t_hr_adj  = hr_edge & ~alarm_sel;
        sec_wrap  = tick1 && (sec == 6'd59);
        min_wrap  = sec_wrap && !t_min_adj && (min == 6'd59);
        sec_nx    = sec;
        min_nx    = min;
        hour_nx   = hour;
        if (tick1)                  sec_nx  = sec_wrap ? 6'd0 : sec + 6'd1;
        if (t_min_adj || sec_wrap)  min_nx  = (min == 6'd59) ? 6'd0 : min + 6'd1;
        if (t_hr_adj || min_wrap)   hour_nx = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    end

    always_comb begin
        h12 = (hour >= 5'd12) ? hour - 5'd12 : hour;
        if (h12 == 5'd0) h12 = 5'd12;
        d_sec  = sec;
        d_min  = min;
        d_hour = mode ? h12 : hour;
        pm     = mode && (hour >= 5'd12);
`ifdef CLOCK_ALARM_EN
        if (alarm_sel) begin
            d_sec  = 6'd0;
            d_min  = amin;
            d_hour = ahour;
            pm     = mode && (ahour >= 5'd12);
        end
`endif
    end

    always_comb begin
        dval  = 4'd0;
        blank = 1'b0;
        case (digit)
            DIG_W'(0): dval  = 4'(d_sec % 6'd10);
            DIG_W'(1): dval  = 4'(d_sec / 6'd10);
            DIG_W'(2): dval  = 4'(d_min % 6'd10);
            DIG_W'(3): dval  = 4'(d_min / 6'd10);
            DIG_W'(4): dval  = 4'(d_hour % 5'd10);
            DIG_W'(5): dval  = 4'(d_hour / 5'd10);
            default:   blank = 1'b1;
        endcase
        seg_nx = blank ? 8'hFF : seg_of(dval);
        if ((digit == DIG_W'(2)) && !alarm_sel && (tick_cnt < CNT_W'(CLK_HZ / 2))) seg_nx[7] = 1'b0;
        select_nx = ~(NUM_DIGITS'(1) << digit);
    end

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            scan_cnt <= '0;
            digit    <= '0;
            min_sync <= '0;
            hr_sync  <= '0;
        end else begin
            tick_cnt <= tick1 ? '0 : tick_cnt + CNT_W'(1);
            min_sync <= {min_sync[1:0], minute_change};
            hr_sync  <= {hr_sync[1:0], hour_change};
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                digit    <= (digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit + DIG_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    // Chime is armed only by a counted rollover into mm:ss = 00:00.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            sec       <= 6'd0;
            min       <= 6'd0;
            hour      <= 5'd0;
            chime_cnt <= '0;
        end else begin
            sec  <= sec_nx;
            min  <= min_nx;
            hour <= hour_nx;
            if (min_wrap)                        chime_cnt <= CHM_W'(CHIME_SEC);
            else if (tick1 && chime_cnt != '0)   chime_cnt <= chime_cnt - CHM_W'(1);
        end
    end

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            select <= '1;
            number <= 8'hFF;
            led1   <= 1'b0;
            led2   <= 1'b0;
            led3   <= 1'b0;
        end else begin
            select <= select_nx;
            number <= seg_nx;
            led1   <= pm;
            led2   <= (chime_cnt != '0);
            led3   <= alarm_match;
        end
    end
endmodule

// File: tb/tb_clock_param.sv
// Randomized self-checking bench for clock_param against a cycle-count based behavioural model.
// Alarm scenarios are exercised only when CLOCK_ALARM_EN is defined.
module tb_clock_param;
    localparam int CLK_HZ     = 20;
    localparam int SCAN_HZ    = 10;
    localparam int NUM_DIGITS = 8;
    localparam int CHIME_SEC  = 3;
    localparam int ALARM_H    = 7;
    localparam int DIV        = CLK_HZ / SCAN_HZ;
    localparam int CHIME_CYC  = CHIME_SEC * CLK_HZ;
    localparam int LIM        = 1500;

    logic       clk = 1'b0;
    logic       rst_n, minute_change, hour_change, mode, alarm_en;
    logic [7:0] select, number;
    logic       led1, led2, led3;

    clock_param #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_DIGITS(NUM_DIGITS),
        .CHIME_SEC(CHIME_SEC), .ALARM_RST_H(ALARM_H)
    ) dut (
        .clk_100Mhz(clk), .rst_n(rst_n), .minute_change(minute_change),
        .hour_change(hour_change), .mode(mode), .alarm_en(alarm_en),
        .select(select), .number(number), .led1(led1), .led2(led2), .led3(led3)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int m_sec, m_min, m_hour, m_amin, m_ahour;
    int chime_at = -1, pend_min = -1, pend_hr = -1;
    bit chk_en = 1'b0;
    logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] sel_exp [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] e_select = 8'hFF, e_number = 8'hFF;
    logic       e_led1 = 1'b0, e_led2 = 1'b0, e_led3 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, required %h", nm, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at cyc %0d", nm, cyc);
    endtask

    function automatic bit alarm_eff();
`ifdef CLOCK_ALARM_EN
        return alarm_en;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] exp_digit(input int d, input int pc, input bit ae);
        int s, mi, h;
        logic [7:0] v;
        if (ae) begin
            s = 0; mi = m_amin; h = m_ahour;
        end else begin
            s = m_sec; mi = m_min; h = m_hour;
            if (mode) h = (h % 12 == 0) ? 12 : h % 12;
        end
        case (d)
            0: v = segtab[s % 10];
            1: v = segtab[s / 10];
            2: v = segtab[mi % 10];
            3: v = segtab[mi / 10];
            4: v = segtab[h % 10];
            5: v = segtab[h / 10];
            default: v = 8'hFF;
        endcase
        if (d == 2 && !ae && pc < CLK_HZ / 2) v[7] = 1'b0;
        return v;
    endfunction

    // One step per clock edge k after reset release; outputs reflect the state before the edge.
    task automatic model_step();
        int k, pc, d, hs;
        bit ae, tick, mi_ev, hr_ev, tm, th;
        logic [7:0] sel;
        cyc++;
        k  = cyc;
        pc = (k - 1) % CLK_HZ;
        d  = ((k - 1) / DIV) % NUM_DIGITS;
        ae = alarm_eff();
        sel = 8'h01;
        sel = sel << d;
        e_select = ~sel;
        e_number = exp_digit(d, pc, ae);
        hs = ae ? m_ahour : m_hour;
        e_led1 = mode && (hs >= 12);
        e_led2 = (chime_at >= 0) && (k > chime_at) && (k <= chime_at + CHIME_CYC);
`ifdef CLOCK_ALARM_EN
        e_led3 = !ae && (m_hour == m_ahour) && (m_min == m_amin);
`else
        e_led3 = 1'b0;
`endif
        tick  = (k % CLK_HZ == 0);
        mi_ev = (pend_min == k);
        hr_ev = (pend_hr == k);
        if (mi_ev) pend_min = -1;
        if (hr_ev) pend_hr = -1;
        tm = mi_ev && !ae;
        th = hr_ev && !ae;
        if (tick) begin
            m_sec++;
            if (m_sec == 60) begin
                m_sec = 0;
                if (!tm) begin
                    m_min++;
                    if (m_min == 60) begin
                        m_min = 0;
                        chime_at = k;
                        if (!th) m_hour = (m_hour + 1) % 24;
                    end
                end
            end
        end
        if (tm) m_min = (m_min + 1) % 60;
        if (th) m_hour = (m_hour + 1) % 24;
        if (mi_ev && ae) m_amin = (m_amin + 1) % 60;
        if (hr_ev && ae) m_ahour = (m_ahour + 1) % 24;
    endtask

    always @(posedge clk) if (rst_n === 1'b1) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("select", select, e_select);
            chk("number", number, e_number);
            chk("led1", led1, e_led1);
            chk("led2", led2, e_led2);
            chk("led3", led3, e_led3);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        minute_change = 1'b0;
        hour_change = 1'b0;
        cyc = 0;
        m_sec = 0; m_min = 0; m_hour = 0; m_amin = 0; m_ahour = ALARM_H;
        chime_at = -1; pend_min = -1; pend_hr = -1;
        e_select = 8'hFF; e_number = 8'hFF; e_led1 = 0; e_led2 = 0; e_led3 = 0;
        #1;
        chk("rst_select", select, 8'hFF);
        chk("rst_number", number, 8'hFF);
        chk("rst_led1", led1, 1'b0);
        chk("rst_led2", led2, 1'b0);
        chk("rst_led3", led3, 1'b0);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Rising edge launched just after edge k0 is applied by the design at edge k0+3.
    task automatic pulse(input bit is_hr);
        @(negedge clk);
        if (is_hr) begin hour_change = 1'b1; pend_hr = cyc + 3; end
        else begin minute_change = 1'b1; pend_min = cyc + 3; end
        repeat (2) @(negedge clk);
        hour_change = 1'b0;
        minute_change = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic get_digit(input int idx, output logic [7:0] val);
        logic [7:0] want;
        bit found;
        found = 1'b0;
        val = 8'h00;
        want = 8'h01;
        want = ~(want << idx);
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (select == want) begin
                val = number;
                found = 1'b1;
            end
        end
        if (!found) timeout_fail("digit_select");
    endtask

    function automatic bit cond(input int kind, input int a, input int b);
        case (kind)
            0: return m_sec == a;
            1: return (m_hour == a) && (m_min == b);
            default: return (m_sec == a) && (cyc % CLK_HZ == b);
        endcase
    endfunction

    task automatic wait_cond(input int kind, input int a, input int b, input string nm);
        int n;
        n = 0;
        while (!cond(kind, a, b) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) timeout_fail(nm);
    endtask

    initial begin
        logic [7:0] v;
        int h0, mb, n;
        rst_n = 1'b0; mode = 1'b0; alarm_en = 1'b0;
        minute_change = 1'b0; hour_change = 1'b0;

        // Reset values and first tick 20 cycles after release.
        do_reset();
        get_digit(0, v);  chk("sec_before_tick", v, 8'hC0);
        while (cyc < 21) @(negedge clk);
        get_digit(0, v);  chk("sec_after_tick", v, 8'hF9);

        // Reset in the middle of 05:17:42.
        repeat (5) pulse(1'b1);
        repeat (17) pulse(1'b0);
        wait_cond(0, 42, 0, "wait_05_17_42");
        get_digit(4, v);  chk("hour_units_5", v, 8'h92);
        do_reset();
        get_digit(0, v);  chk("sec_zero_after_rst", v, 8'hC0);
        get_digit(4, v);  chk("hour_zero_after_rst", v, 8'hC0);

        // 23:59:59 rollover, chime and 12-hour display.
        @(negedge clk) mode = 1'b1;
        repeat (23) pulse(1'b1);
        repeat (59) pulse(1'b0);
        get_digit(5, v);  chk("h23_12h_tens", v, 8'hF9);
        get_digit(4, v);  chk("h23_12h_units", v, 8'hF9);
        chk("h23_led1", led1, 1'b1);
        wait_cond(1, 0, 0, "wait_rollover");
        chk("led2_before_rise", led2, 1'b0);
        @(negedge clk);
        chk("led2_rise", led2, 1'b1);
        chk("led1_midnight", led1, 1'b0);
        repeat (CHIME_CYC - 1) @(negedge clk);
        chk("led2_last", led2, 1'b1);
        @(negedge clk);
        chk("led2_fall", led2, 1'b0);
        get_digit(5, v);  chk("h0_12h_tens", v, 8'hF9);
        get_digit(4, v);  chk("h0_12h_units", v, 8'hA4);
        repeat (13) pulse(1'b1);
        get_digit(5, v);  chk("h13_12h_tens", v, 8'hC0);
        get_digit(4, v);  chk("h13_12h_units", v, 8'hF9);
        chk("h13_led1", led1, 1'b1);

        // Minute adjust wraps without carry; adjust coincident with a tick.
        @(negedge clk) mode = 1'b0;
        wait_cond(0, 5, 0, "wait_sec5");
        n = 0;
        while (m_min != 59 && n < 60) begin pulse(1'b0); n++; end
        h0 = m_hour;
        pulse(1'b0);
        get_digit(3, v);  chk("min_wrap_tens", v, 8'hC0);
        get_digit(2, v);  chk("min_wrap_units", v | 8'h80, 8'hC0);
        get_digit(4, v);  chk("min_wrap_hour", v, segtab[h0 % 10]);
        wait_cond(2, 59, CLK_HZ - 4, "wait_coincide");
        mb = m_min;
        pulse(1'b0);
        get_digit(0, v);  chk("coincide_sec", v, 8'hC0);
        get_digit(2, v);  chk("coincide_min", v | 8'h80, segtab[((mb + 1) % 60) % 10]);

`ifdef CLOCK_ALARM_EN
        // Alarm adjust/display and 60 s alarm LED.
        @(negedge clk) alarm_en = 1'b1;
        pulse(1'b1);
        pulse(1'b1);
        get_digit(5, v);  chk("alarm_h_tens", v, 8'hC0);
        get_digit(4, v);  chk("alarm_h_units", v, 8'h90);
        get_digit(3, v);  chk("alarm_m_tens", v, 8'hC0);
        get_digit(0, v);  chk("alarm_sec0", v, 8'hC0);
        get_digit(1, v);  chk("alarm_sec1", v, 8'hC0);
        @(negedge clk) alarm_en = 1'b0;
        wait_cond(0, 2, 0, "wait_sec2");
        n = 0;
        while (m_hour != 8 && n < 30) begin pulse(1'b1); n++; end
        n = 0;
        while (m_min != 59 && n < 60) begin pulse(1'b0); n++; end
        wait_cond(1, 9, 0, "wait_alarm_time");
        chk("led3_before", led3, 1'b0);
        @(negedge clk);
        chk("led3_rise", led3, 1'b1);
        repeat (60 * CLK_HZ - 1) @(negedge clk);
        chk("led3_last", led3, 1'b1);
        @(negedge clk);
        chk("led3_fall", led3, 1'b0);
`else
        // Without the alarm build, alarm_en is ignored and adjusts target the time.
        @(negedge clk) alarm_en = 1'b1;
        h0 = m_hour;
        pulse(1'b1);
        get_digit(4, v);  chk("noalarm_hour_adj", v, segtab[((h0 + 1) % 24) % 10]);
        chk("noalarm_led3", led3, 1'b0);
        @(negedge clk) alarm_en = 1'b0;
`endif

        // Scan order over one full digit cycle.
        n = 0;
        while (select != 8'hFE && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) timeout_fail("scan_start");
        for (int i = 0; i < NUM_DIGITS; i++) begin
            chk("scan_select", select, sel_exp[i]);
            if (i >= 6) chk("scan_blank", number, 8'hFF);
            repeat (DIV) @(negedge clk);
        end

        // Randomized adjusts, mode and alarm_en changes, checked every cycle by the model.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: pulse(1'b0);
                1: pulse(1'b1);
                2: @(negedge clk) mode = ~mode;
                3: @(negedge clk) alarm_en = ~alarm_en;
                default: repeat ($urandom_range(1, 40)) @(negedge clk);
            endcase
        end
        @(negedge clk) alarm_en = 1'b0;
        repeat (CLK_HZ) @(negedge clk);
`ifndef CLOCK_ALARM_EN
        chk("noalarm_led3_end", led3, 1'b0);
`endif
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
